sram_port_arbiter: RTL and testbench

//  Shares the single-port SRAM (16-bit address, 32-bit data, 1-cycle read latency) between the CPU control
//  FSM and the DMA engine. Fixed priority goes to the CPU; the DMA is served in idle slots. A starvation

---
 rtl/sram_port_arbiter_pkg.sv | 15 +
 rtl/sram_port_arbiter_if.sv | 45 ++++
 rtl/sram_port_arbiter_starve_counter.sv | 25 ++
 rtl/sram_port_arbiter.sv | 113 +++++++++++
 tb/tb_sram_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package sram_port_arbiter_pkg;

   localparam int unsigned ADDR_W             = 16;
   localparam int unsigned DATA_W             = 32;
   localparam int unsigned ARB_STARVE_DEFAULT = 8;
   localparam int unsigned STARVE_CNT_W       = 8;

   typedef enum logic [1:0] {
      ARB_OWNER_NONE = 2'd0,
      ARB_OWNER_CPU  = 2'd1,
      ARB_OWNER_DMA  = 2'd2
   } arb_owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// CPU, DMA and SRAM-macro signals of the arbiter, grouped as one bus.
interface sram_port_arbiter_if;
   import sram_port_arbiter_pkg::*;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_di;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_di;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] sram_ADDR;
   logic [DATA_W-1:0] sram_DI;
   logic              sram_EN;
   logic              sram_WE;
   logic [DATA_W-1:0] sram_DO;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_di,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_di,
      output dma_gnt, dma_rvalid, dma_rdata,
      output sram_ADDR, sram_DI, sram_EN, sram_WE,
      input  sram_DO
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_di,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_di,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  sram_ADDR, sram_DI, sram_EN, sram_WE,
      output sram_DO
   );

endinterface

// File: rtl/sram_port_arbiter_starve_counter.sv
// Saturating count of consecutive DMA-denied cycles; flags a forced DMA slot at the limit.
module arb_starve_counter
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = ARB_STARVE_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic force_slot
);

   logic [STARVE_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (inc && (cnt < STARVE_CNT_W'(LIMIT)))
         cnt <= cnt + 1'b1;
   end

   assign force_slot = (cnt >= STARVE_CNT_W'(LIMIT));

endmodule

// File: rtl/sram_port_arbiter.sv
// CPU/DMA arbiter for the single-port SRAM: CPU priority, starvation-forced DMA slots,
// read data routed back to the issuing side, stall statistics.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = ARB_STARVE_DEFAULT,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   sram_port_arbiter_if.slave bus,
   output logic             starve_force,
   output logic [CNT_W-1:0] cpu_stall_cnt,
   output logic [CNT_W-1:0] dma_stall_cnt
);

   logic              force_slot;
   logic              cpu_gnt;
   logic              dma_gnt;
   logic              cpu_rvalid;
   logic              dma_rvalid;
   arb_owner_e        rd_owner;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk        (clk),
      .reset      (reset),
      .inc        (bus.dma_req && !dma_gnt),
      .clr        (dma_gnt || !bus.dma_req),
      .force_slot (force_slot)
   );

   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!reset) begin
         if (force_slot && bus.dma_req)
            dma_gnt = 1'b1;
         else if (bus.cpu_req)
            cpu_gnt = 1'b1;
         else if (bus.dma_req)
            dma_gnt = 1'b1;
      end
   end

   always_comb begin
      bus.sram_ADDR = '0;
      bus.sram_DI   = '0;
      bus.sram_WE   = 1'b0;
      if (cpu_gnt) begin
         bus.sram_ADDR = bus.cpu_addr;
         bus.sram_DI   = bus.cpu_di;
         bus.sram_WE   = bus.cpu_we;
      end else if (dma_gnt) begin
         bus.sram_ADDR = bus.dma_addr;
         bus.sram_DI   = bus.dma_di;
         bus.sram_WE   = bus.dma_we;
      end
   end

   assign bus.sram_EN = cpu_gnt || dma_gnt;
   assign bus.cpu_gnt = cpu_gnt;
   assign bus.dma_gnt = dma_gnt;
   assign starve_force = force_slot && bus.dma_req && !reset;

   always_ff @(posedge clk) begin
      if (reset)
         rd_owner <= ARB_OWNER_NONE;
      else if (cpu_gnt && !bus.cpu_we)
         rd_owner <= ARB_OWNER_CPU;
      else if (dma_gnt && !bus.dma_we)
         rd_owner <= ARB_OWNER_DMA;
      else
         rd_owner <= ARB_OWNER_NONE;
   end

   // SRAM data arrives in the rvalid cycle, so it is passed through then and held afterwards.
   assign cpu_rvalid = (rd_owner == ARB_OWNER_CPU) && !reset;
   assign dma_rvalid = (rd_owner == ARB_OWNER_DMA) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         if (cpu_rvalid)
            cpu_rdata_q <= bus.sram_DO;
         if (dma_rvalid)
            dma_rdata_q <= bus.sram_DO;
      end
   end

   assign bus.cpu_rvalid = cpu_rvalid;
   assign bus.dma_rvalid = dma_rvalid;
   assign bus.cpu_rdata  = cpu_rvalid ? bus.sram_DO : cpu_rdata_q;
   assign bus.dma_rdata  = dma_rvalid ? bus.sram_DO : dma_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_stall_cnt <= '0;
         dma_stall_cnt <= '0;
      end else begin
         if (bus.cpu_req && !cpu_gnt)
            cpu_stall_cnt <= cpu_stall_cnt + 1'b1;
         if (bus.dma_req && !dma_gnt)
            dma_stall_cnt <= dma_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small behavioural SRAM (1-cycle read latency).
module tb_sram_port_arbiter;
   import sram_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        starve_force;
   logic [31:0] cpu_stall_cnt;
   logic [31:0] dma_stall_cnt;
   logic [31:0] mem [0:255];
   int          checks = 0;
   int          errors = 0;

   sram_port_arbiter_if bus ();

   sram_port_arbiter #(
      .STARVE_LIMIT (8),
      .CNT_W        (32)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .starve_force  (starve_force),
      .cpu_stall_cnt (cpu_stall_cnt),
      .dma_stall_cnt (dma_stall_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.sram_EN) begin
         if (bus.sram_WE)
            mem[bus.sram_ADDR[7:0]] <= bus.sram_DI;
         else
            bus.sram_DO <= mem[bus.sram_ADDR[7:0]];
      end
   end

   task automatic idle_inputs();
      bus.cpu_req  = 1'b0;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_di   = '0;
      bus.dma_req  = 1'b0;
      bus.dma_we   = 1'b0;
      bus.dma_addr = '0;
      bus.dma_di   = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.cpu_gnt, bus.dma_gnt, bus.sram_EN} !== 3'b000) begin
         errors++;
         $display("FAIL reset_gnt_en: got %b expected 000", {bus.cpu_gnt, bus.dma_gnt, bus.sram_EN});
      end
      checks++;
      if ({bus.cpu_rvalid, bus.dma_rvalid, starve_force} !== 3'b000) begin
         errors++;
         $display("FAIL reset_rvalid: got %b expected 000", {bus.cpu_rvalid, bus.dma_rvalid, starve_force});
      end
      checks++;
      if (cpu_stall_cnt !== 32'd0 || dma_stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", cpu_stall_cnt, dma_stall_cnt);
      end
      checks++;
      if (bus.cpu_rdata !== 32'd0 || bus.dma_rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.cpu_rdata, bus.dma_rdata);
      end
   endtask

   task automatic test_cpu_read();
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 16'h0010;
      #1;
      checks++;
      if ({bus.cpu_gnt, bus.dma_gnt, bus.sram_EN, bus.sram_WE} !== 4'b1010) begin
         errors++;
         $display("FAIL cpu_read_gnt: got %b expected 1010", {bus.cpu_gnt, bus.dma_gnt, bus.sram_EN, bus.sram_WE});
      end
      checks++;
      if (bus.sram_ADDR !== 16'h0010) begin
         errors++;
         $display("FAIL cpu_read_addr: got %h expected 0010", bus.sram_ADDR);
      end
      @(negedge clk);
      bus.cpu_req = 1'b0;
      #1;
      checks++;
      if (bus.cpu_rvalid !== 1'b1 || bus.dma_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL cpu_read_rvalid: got %b%b expected 10", bus.cpu_rvalid, bus.dma_rvalid);
      end
      checks++;
      if (bus.cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL cpu_read_data: got %h expected deadbeef", bus.cpu_rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL cpu_read_hold: got %b %h expected 0 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
      end
   endtask

   task automatic test_starvation();
      logic exp_dma;
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = 16'h00F0;
      bus.cpu_di   = 32'hC0C0C0C0;
      bus.dma_req  = 1'b1;
      bus.dma_we   = 1'b1;
      bus.dma_addr = 16'h00F1;
      bus.dma_di   = 32'hD0D0D0D0;
      for (int i = 0; i < 20; i++) begin
         #1;
         exp_dma = (i == 8) || (i == 17);
         checks++;
         if ({bus.cpu_gnt, bus.dma_gnt, starve_force} !== {!exp_dma, exp_dma, exp_dma}) begin
            errors++;
            $display("FAIL starve_cycle%0d: got cpu/dma/force %b expected %b", i,
                     {bus.cpu_gnt, bus.dma_gnt, starve_force}, {!exp_dma, exp_dma, exp_dma});
         end
         @(negedge clk);
      end
      idle_inputs();
      #1;
      checks++;
      if (dma_stall_cnt !== 32'd18 || cpu_stall_cnt !== 32'd2) begin
         errors++;
         $display("FAIL starve_stats: got dma %0d cpu %0d expected dma 18 cpu 2", dma_stall_cnt, cpu_stall_cnt);
      end
   endtask

   task automatic test_write_then_read();
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = 16'h0005;
      bus.cpu_di   = 32'h00001234;
      #1;
      checks++;
      if ({bus.cpu_gnt, bus.sram_WE} !== 2'b11 || bus.sram_DI !== 32'h00001234) begin
         errors++;
         $display("FAIL wr_cycle: got gnt/we %b di %h expected 11 00001234", {bus.cpu_gnt, bus.sram_WE}, bus.sram_DI);
      end
      @(negedge clk);
      idle_inputs();
      bus.dma_req  = 1'b1;
      bus.dma_we   = 1'b0;
      bus.dma_addr = 16'h0005;
      #1;
      checks++;
      if ({bus.dma_gnt, bus.sram_WE, bus.cpu_rvalid} !== 3'b100) begin
         errors++;
         $display("FAIL wr_then_rd_issue: got gnt/we/cpu_rvalid %b expected 100", {bus.dma_gnt, bus.sram_WE, bus.cpu_rvalid});
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if ({bus.dma_rvalid, bus.cpu_rvalid} !== 2'b10 || bus.dma_rdata !== 32'h00001234) begin
         errors++;
         $display("FAIL wr_then_rd_data: got rvalid %b data %h expected 10 00001234",
                  {bus.dma_rvalid, bus.cpu_rvalid}, bus.dma_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_cv;
      logic exp_dv;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k < 4 && (k % 2) == 0) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 16'h0001;
         end else if (k < 4) begin
            bus.dma_req  = 1'b1;
            bus.dma_addr = 16'h0002;
         end
         #1;
         exp_cv = (k > 0) && ((k - 1) % 2 == 0);
         exp_dv = (k > 0) && ((k - 1) % 2 == 1);
         checks++;
         if ({bus.cpu_gnt, bus.dma_gnt} !== {(k < 4) && (k % 2 == 0), (k < 4) && (k % 2 == 1)}) begin
            errors++;
            $display("FAIL b2b_gnt%0d: got %b%b", k, bus.cpu_gnt, bus.dma_gnt);
         end
         checks++;
         if ({bus.cpu_rvalid, bus.dma_rvalid} !== {exp_cv, exp_dv}) begin
            errors++;
            $display("FAIL b2b_rvalid%0d: got %b%b expected %b%b", k, bus.cpu_rvalid, bus.dma_rvalid, exp_cv, exp_dv);
         end
         if (exp_cv) begin
            checks++;
            if (bus.cpu_rdata !== 32'h11111111) begin
               errors++;
               $display("FAIL b2b_cpu_data%0d: got %h expected 11111111", k, bus.cpu_rdata);
            end
         end
         if (exp_dv) begin
            checks++;
            if (bus.dma_rdata !== 32'h22222222) begin
               errors++;
               $display("FAIL b2b_dma_data%0d: got %h expected 22222222", k, bus.dma_rdata);
            end
         end
      end
   endtask

   task automatic test_withdraw();
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = 16'h00F0;
      bus.dma_req  = 1'b1;
      bus.dma_we   = 1'b1;
      bus.dma_addr = 16'h00F1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({bus.cpu_gnt, bus.dma_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL withdraw_pre%0d: got %b%b expected 10", i, bus.cpu_gnt, bus.dma_gnt);
         end
         @(negedge clk);
      end
      bus.dma_req = 1'b0;
      #1;
      checks++;
      if ({bus.cpu_gnt, bus.dma_gnt, starve_force} !== 3'b100 || dma_stall_cnt !== 32'd26) begin
         errors++;
         $display("FAIL withdraw_noforce: got %b stall %0d expected 100 stall 26",
                  {bus.cpu_gnt, bus.dma_gnt, starve_force}, dma_stall_cnt);
      end
      @(negedge clk);
      bus.dma_req = 1'b1;
      #1;
      checks++;
      if ({bus.cpu_gnt, starve_force} !== 2'b10 || dma_stall_cnt !== 32'd26) begin
         errors++;
         $display("FAIL withdraw_rearm: got %b stall %0d expected 10 stall 26",
                  {bus.cpu_gnt, starve_force}, dma_stall_cnt);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (dma_stall_cnt !== 32'd27 || cpu_stall_cnt !== 32'd2) begin
         errors++;
         $display("FAIL withdraw_stats: got dma %0d cpu %0d expected 27 2", dma_stall_cnt, cpu_stall_cnt);
      end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 16'h0010;
      #1;
      checks++;
      if (bus.cpu_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_issue: got %b expected 1", bus.cpu_gnt);
      end
      @(negedge clk);
      reset       = 1'b1;
      bus.dma_req = 1'b1;
      #1;
      checks++;
      if ({bus.cpu_rvalid, bus.cpu_gnt, bus.dma_gnt, bus.sram_EN, bus.sram_WE} !== 5'b00000) begin
         errors++;
         $display("FAIL rst_mid_during: got %b expected 00000",
                  {bus.cpu_rvalid, bus.cpu_gnt, bus.dma_gnt, bus.sram_EN, bus.sram_WE});
      end
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if ({bus.cpu_rvalid, bus.dma_rvalid, starve_force} !== 3'b000) begin
         errors++;
         $display("FAIL rst_mid_rvalid: got %b expected 000", {bus.cpu_rvalid, bus.dma_rvalid, starve_force});
      end
      checks++;
      if (cpu_stall_cnt !== 32'd0 || dma_stall_cnt !== 32'd0 ||
          bus.cpu_rdata !== 32'd0 || bus.dma_rdata !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_state: got stalls %0d/%0d rdata %h/%h expected all 0",
                  cpu_stall_cnt, dma_stall_cnt, bus.cpu_rdata, bus.dma_rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.cpu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_late: got %b expected 0", bus.cpu_rvalid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 256; a++)
         mem[a] = '0;
      mem[8'h10]  = 32'hDEADBEEF;
      mem[8'h01]  = 32'h11111111;
      mem[8'h02]  = 32'h22222222;
      bus.sram_DO = '0;
      test_reset();
      test_cpu_read();
      test_starvation();
      test_write_then_read();
      test_back_to_back();
      test_withdraw();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
